// File: rtl/hazard3_pmp_cfg_loader.sv
// ============================================================================
// hazard3_pmp_cfg_loader : boot-time PMP configuration sequencer fed from a table ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard3_pmp_cfg_loader #(
    parameter int TBL_DEPTH  = 16,
    parameter int W_TBL_ADDR = $clog2(TBL_DEPTH),
    parameter bit AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  tbl_ren,
    output logic [W_TBL_ADDR-1:0] tbl_addr,
    input  logic [44:0]           tbl_rdata,
    output logic [11:0]           cfg_addr,
    output logic                  cfg_wen,
    output logic [31:0]           cfg_wdata,
    input  logic [31:0]           cfg_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [W_TBL_ADDR-1:0] err_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        RDATA = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic [W_TBL_ADDR-1:0] LAST_IDX = W_TBL_ADDR'(TBL_DEPTH - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [W_TBL_ADDR-1:0]   index;
    logic [W_TBL_ADDR-1:0]   index_nxt;
    logic [W_TBL_ADDR-1:0]   err_idx_nxt;
    logic                    ent_load;
    logic                    ent_verify;
    logic [11:0]             ent_addr;
    logic [31:0]             ent_data;
    logic                    auto_pend;
    logic                    start_req;

    // auto_pend stands in for a start pulse during the first post-reset cycle
    assign start_req = start | auto_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            err_idx    <= '0;
            auto_pend  <= AUTO_START;
            ent_verify <= 1'b0;
            ent_addr   <= '0;
            ent_data   <= '0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            err_idx   <= err_idx_nxt;
            auto_pend <= 1'b0;
            if (ent_load) begin
                ent_verify <= tbl_rdata[44];
                ent_addr   <= tbl_rdata[43:32];
                ent_data   <= tbl_rdata[31:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        err_idx_nxt = err_idx;
        ent_load    = 1'b0;
        tbl_ren     = 1'b0;
        tbl_addr    = '0;
        cfg_wen     = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (state)
            IDLE, DONE, ERROR: begin
                done = (state == DONE);
                err  = (state == ERROR);
                if (start_req) begin
                    state_nxt = FETCH;
                    index_nxt = '0;
                end
            end
            FETCH: begin
                busy      = 1'b1;
                tbl_ren   = 1'b1;
                tbl_addr  = index;
                state_nxt = RDATA;
            end
            RDATA: begin
                busy = 1'b1;
                // A zero CSR address marks the end of the table
                if (tbl_rdata[43:32] == 12'h000) begin
                    state_nxt = DONE;
                end else begin
                    ent_load  = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                cfg_wen   = 1'b1;
                cfg_addr  = ent_addr;
                cfg_wdata = ent_data;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                cfg_addr  = ent_addr;
                cfg_wdata = ent_data;
                // Locked PMP entries drop writes silently; only verify can catch that
                if (ent_verify && (cfg_rdata != ent_data)) begin
                    state_nxt   = ERROR;
                    err_idx_nxt = index;
                end else if (index == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    index_nxt = index + W_TBL_ADDR'(1);
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard3_pmp_cfg_loader.sv
// Directed bench for hazard3_pmp_cfg_loader with a one-cycle table ROM and an echoing PMP model.
`default_nettype none

module tb_hazard3_pmp_cfg_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          tbl_ren;
    logic [AW-1:0] tbl_addr;
    logic [44:0]   tbl_rdata;
    logic [11:0]   cfg_addr;
    logic          cfg_wen;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] err_idx;

    hazard3_pmp_cfg_loader #(
        .TBL_DEPTH (DEPTH),
        .W_TBL_ADDR(AW),
        .AUTO_START(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tbl_ren  (tbl_ren),
        .tbl_addr (tbl_addr),
        .tbl_rdata(tbl_rdata),
        .cfg_addr (cfg_addr),
        .cfg_wen  (cfg_wen),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table ROM: one-cycle read latency
    logic [44:0] rom [0:DEPTH-1];
    always @(posedge clk) begin
        if (tbl_ren) tbl_rdata <= rom[tbl_addr];
    end

    // PMP model: echoes writes, optionally masks pmpaddr0 low bits on read-back
    logic [31:0] pmp_mem [0:4095];
    logic        mask_mode;
    always @(posedge clk) begin
        if (cfg_wen) pmp_mem[cfg_addr] <= cfg_wdata;
    end
    always_comb begin
        cfg_rdata = pmp_mem[cfg_addr];
        if (mask_mode && cfg_addr == 12'h3B0) cfg_rdata = pmp_mem[cfg_addr] & 32'hFFFF_FFFC;
    end

    int total;
    int bad;

    int          busy_cnt;
    int          wr_cnt;
    int          max_addr;
    int          first_addr;
    int          viol;
    logic [11:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Watch one sequence on negedges; optional start pulses at loop indices p0/p1.
    task automatic run_seq(input string tag, input int p0, input int p1);
        bit   seen;
        logic prev_wen;
        logic [11:0] prev_addr;
        seen = 0; busy_cnt = 0; wr_cnt = 0; max_addr = 0; first_addr = -1; viol = 0;
        prev_wen = 0; prev_addr = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                busy_cnt++;
            end else if (seen) begin
                break;
            end
            if (cfg_wen) begin
                if (wr_cnt < 8) begin
                    wr_addr[wr_cnt] = cfg_addr;
                    wr_data[wr_cnt] = cfg_wdata;
                end
                wr_cnt++;
            end
            if (tbl_ren) begin
                if (first_addr < 0) first_addr = int'(tbl_addr);
                if (int'(tbl_addr) > max_addr) max_addr = int'(tbl_addr);
                if (cfg_addr != 0 || cfg_wdata != 0) viol++;
            end
            if (!busy && (cfg_addr != 0 || cfg_wen || tbl_ren)) viol++;
            if (prev_wen && (cfg_wen || cfg_addr != prev_addr)) viol++;
            prev_wen  = cfg_wen;
            prev_addr = cfg_addr;
            start = (c == p0 || c == p1);
        end
        start = 1'b0;
        check_eq({tag, "_terminated"}, {63'd0, seen && !busy}, 64'd1);
        check_eq({tag, "_iface_rules"}, 64'(viol), 64'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        start = 1'b0; mask_mode = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) pmp_mem[i] = 32'h0;
        rom[0] = {1'b1, 12'h3A0, 32'h0000_001F};
        rom[1] = {1'b1, 12'h3B0, 32'h1000_03FF};
        rom[2] = 45'd0;
        rom[3] = 45'd0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_err", {63'd0, err}, 64'd0);
        check_eq("rst_ren_wen", {62'd0, tbl_ren, cfg_wen}, 64'd0);
        check_eq("rst_err_idx", 64'(err_idx), 64'd0);

        // Auto-start after reset: two verified entries then terminator
        rst_n = 1'b1;
        run_seq("basic", -1, -1);
        check_eq("basic_busy", 64'(busy_cnt), 64'd10);
        check_eq("basic_writes", 64'(wr_cnt), 64'd2);
        check_eq("basic_w0", {20'd0, wr_addr[0], wr_data[0]}, {20'd0, 12'h3A0, 32'h0000_001F});
        check_eq("basic_w1", {20'd0, wr_addr[1], wr_data[1]}, {20'd0, 12'h3B0, 32'h1000_03FF});
        check_eq("basic_done_err", {62'd0, done, err}, 64'b10);
        check_eq("basic_max_addr", 64'(max_addr), 64'd2);

        // Start while busy is ignored
        run_seq("midstart", 0, 5);
        check_eq("midstart_busy", 64'(busy_cnt), 64'd10);
        check_eq("midstart_writes", 64'(wr_cnt), 64'd2);
        check_eq("midstart_done", {63'd0, done}, 64'd1);

        // Masked read-back of pmpaddr0 trips verify on entry 1
        mask_mode = 1'b1;
        run_seq("mask", 0, -1);
        check_eq("mask_busy", 64'(busy_cnt), 64'd8);
        check_eq("mask_writes", 64'(wr_cnt), 64'd2);
        check_eq("mask_done_err", {62'd0, done, err}, 64'b01);
        check_eq("mask_err_idx", 64'(err_idx), 64'd1);

        // Start from ERROR reruns the whole table
        mask_mode = 1'b0;
        run_seq("rerun", 0, -1);
        check_eq("rerun_first_addr", 64'(first_addr), 64'd0);
        check_eq("rerun_busy", 64'(busy_cnt), 64'd10);
        check_eq("rerun_done_err", {62'd0, done, err}, 64'b10);

        // Verify disabled: masked read-back goes unnoticed
        rom[0][44] = 1'b0;
        rom[1][44] = 1'b0;
        mask_mode  = 1'b1;
        run_seq("noverify", 0, -1);
        check_eq("noverify_busy", 64'(busy_cnt), 64'd10);
        check_eq("noverify_done_err", {62'd0, done, err}, 64'b10);

        // Terminator as first entry
        rom[0] = 45'd0;
        run_seq("empty", 0, -1);
        check_eq("empty_busy", 64'(busy_cnt), 64'd2);
        check_eq("empty_writes", 64'(wr_cnt), 64'd0);
        check_eq("empty_done", {63'd0, done}, 64'd1);

        // Full table without terminator
        mask_mode = 1'b0;
        rom[0] = {1'b1, 12'h3A0, 32'h0000_001F};
        rom[1] = {1'b1, 12'h3B0, 32'h1000_03FF};
        rom[2] = {1'b1, 12'h3B1, 32'h2000_0FFF};
        rom[3] = {1'b1, 12'h3A1, 32'h0000_1B00};
        run_seq("full", 0, -1);
        check_eq("full_busy", 64'(busy_cnt), 64'd16);
        check_eq("full_writes", 64'(wr_cnt), 64'd4);
        check_eq("full_max_addr", 64'(max_addr), 64'd3);
        check_eq("full_w3", {20'd0, wr_addr[3], wr_data[3]}, {20'd0, 12'h3A1, 32'h0000_1B00});
        check_eq("full_done_err", {62'd0, done, err}, 64'b10);

        // Error first so err_idx is nonzero, then reset in the second WRITE
        begin
            int  wseen;
            bit  hit;
            wseen = 0; hit = 0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 100 && !hit; c++) begin
                if (cfg_wen) begin
                    wseen++;
                    if (wseen == 2) hit = 1;
                end
                if (!hit) @(negedge clk);
            end
            check_eq("rstw_reached_write", {63'd0, hit}, 64'd1);
            rst_n = 1'b0;
            #1;
            check_eq("rstw_wen_async", {63'd0, cfg_wen}, 64'd0);
            check_eq("rstw_busy_async", {63'd0, busy}, 64'd0);
            @(negedge clk);
            check_eq("rstw_err_idx", 64'(err_idx), 64'd0);
            rst_n = 1'b1;
            run_seq("rstw", -1, -1);
            check_eq("rstw_first_addr", 64'(first_addr), 64'd0);
            check_eq("rstw_writes", 64'(wr_cnt), 64'd4);
            check_eq("rstw_busy", 64'(busy_cnt), 64'd16);
            check_eq("rstw_done", {63'd0, done}, 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
